// File: rtl/instr_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Instruction source for the 9-bit simple processor. Holds a loadable program
// memory, walks it with a program counter and hands each instruction word to
// the processor on DIN with a one-cycle Run pulse. For mvi (opcode 001) the
// immediate word follows on DIN in the next cycle. After each issue the block
// waits for Done before fetching again; the word 9'h1FF halts execution.
//
// Ports:
//   Clock   in        rising-edge clock
//   Reset   in        asynchronous, active-high reset
//   Load    in        program-memory write strobe (ignored while Busy)
//   LdAddr  in  AW    write address
//   LdData  in  9     write data
//   Start   in        begin execution from address 0 (ignored while Busy)
//   Step    in        single-step release (only with IFS_SINGLE_STEP_EN)
//   Done    in        processor instruction-complete pulse (used in WAIT only)
//   DIN     out 9     registered word to the processor
//   Run     out       registered instruction-valid pulse
//   PC      out AW    current program counter
//   Busy    out       high in ISSUE, IMM, WAIT (and STEP)
//   Halted  out       high in HALT
//
// Configuration:
//   IFS_SINGLE_STEP_EN  when defined, adds the Step port and a STEP state that
//                       holds off each fetch after Done until Step is seen.
// ---------------------------------------------------------------------------
module instr_fetch_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Load,
  input  logic [AW-1:0] LdAddr,
  input  logic [8:0]    LdData,
  input  logic          Start,
`ifdef IFS_SINGLE_STEP_EN
  input  logic          Step,
`endif
  input  logic          Done,
  output logic [8:0]    DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted
);

  localparam logic [8:0] HALT_WORD  = 9'h1FF;
  localparam logic [2:0] OPCODE_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
`ifdef IFS_SINGLE_STEP_EN
    S_STEP,
`endif
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    din_q, din_d;
  logic          run_q, run_d;
  logic [AW-1:0] pc_q, pc_d;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] fetch_addr;
  logic [8:0]    fetch_word;
  logic          issue_req;

  // NOTE: program memory has no reset on purpose so a program survives Reset;
  // keeping it out of the reset block also lets it map onto RAM.
  always_ff @(posedge Clock) begin
    if (Load && !Busy) begin
      mem[LdAddr] <= LdData;
    end
  end

  // Single read port. Start fetches address 0, ISSUE pre-fetches the mvi
  // immediate at PC+1 (wrapping naturally in AW bits), WAIT/STEP fetch at PC.
  always_comb begin
    fetch_addr = pc_q;
    unique case (state_q)
      S_IDLE, S_HALT: fetch_addr = '0;
      S_ISSUE:        fetch_addr = pc_q + AW'(1);
      default:        fetch_addr = pc_q;
    endcase
  end

  assign fetch_word = mem[fetch_addr];

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    run_d     = 1'b0;
    pc_d      = pc_q;
    issue_req = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          pc_d      = '0;
          issue_req = 1'b1;
        end
      end
      S_ISSUE: begin
        pc_d = pc_q + AW'(1);
        if (din_q[8:6] == OPCODE_MVI) begin
          // Immediate must be on DIN in the cycle right after Run.
          din_d   = fetch_word;
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM: begin
        pc_d    = pc_q + AW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Start is dropped here even when it coincides with Done.
        if (Done) begin
`ifdef IFS_SINGLE_STEP_EN
          if (Step) issue_req = 1'b1;
          else      state_d   = S_STEP;
`else
          issue_req = 1'b1;
`endif
        end
      end
`ifdef IFS_SINGLE_STEP_EN
      S_STEP: begin
        if (Step) issue_req = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // The HALT decision is made on the edge that would otherwise enter ISSUE;
    // a HALT word is never presented and PC stays on its address.
    if (issue_req) begin
      if (fetch_word == HALT_WORD) begin
        state_d = S_HALT;
      end else begin
        din_d   = fetch_word;
        run_d   = 1'b1;
        state_d = S_ISSUE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      din_q   <= '0;
      run_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
    end
  end

  assign DIN    = din_q;
  assign Run    = run_q;
  assign PC     = pc_q;
  assign Halted = (state_q == S_HALT);
`ifdef IFS_SINGLE_STEP_EN
  assign Busy   = (state_q == S_ISSUE) || (state_q == S_IMM) ||
                  (state_q == S_WAIT)  || (state_q == S_STEP);
`else
  assign Busy   = (state_q == S_ISSUE) || (state_q == S_IMM) ||
                  (state_q == S_WAIT);
`endif

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Upstream instruction source for the 9-bit simple processor. Holds a loadable program memory, walks it with a program counter, and presents each instruction word on `DIN` with a one-cycle `Run` pulse. It supplies the immediate word for `mvi` on the following cycle, then waits for the processor's `Done` before issuing the next instruction. Execution stops at a HALT word.

## Interface
Parameters:
- `DEPTH`, 16: program memory words; power of two.
- `AW`, 4: address width, log2(`DEPTH`).

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Load`  in  1  program-memory write strobe.
- `LdAddr`  in  AW  write address.
- `LdData`  in  9  write data.
- `Start`  in  1  begin execution from address 0.
- `Done`  in  1  processor instruction-complete pulse.
- `DIN`  out  9  word to processor; registered.
- `Run`  out  1  instruction-valid pulse; registered.
- `PC`  out  AW  current program counter.
- `Busy`  out  1  high in ISSUE, IMM and WAIT.
- `Halted`  out  1  high in HALT.

## Operation
- Word format: `III XXX YYY`. Opcode `001` is `mvi`. Word `9'h1FF` is HALT and is never issued.
- Memory writes: `mem[LdAddr] <= LdData` when `Load` is high and `Busy` is low. `Load` is ignored while `Busy` is high. Memory is not cleared by `Reset`.
- States are IDLE, ISSUE, IMM, WAIT and HALT.
- IDLE → ISSUE on `Start`, with `PC <= 0`.
- Entry to ISSUE:
  - The fetch of `mem[PC]` is decided at the edge that would enter ISSUE.
  - If the word is `9'h1FF`, go to HALT instead. `Run` stays low and `PC` is held at the HALT address.
  - Otherwise, `DIN <= mem[PC]` and `Run <= 1`.
- ISSUE (1 cycle): `PC <= PC+1`. Go to IMM if opcode `001`, else go to WAIT.
- IMM (1 cycle): `DIN <= mem[PC]` (immediate), `Run` low, `PC <= PC+1`, then go to WAIT.
- WAIT: hold `DIN`, `Run` low. On `Done`, go to ISSUE using the same HALT check.
- HALT: `Halted=1`. `Start` → ISSUE with `PC <= 0`. `Load` is accepted in HALT.
- `PC` wraps from `DEPTH-1` to 0 with no flag. An `mvi` at `DEPTH-1` takes its immediate from address 0.
- `Start` is ignored while `Busy` is high.
- `Done` is ignored outside WAIT.
- If `Done` and `Start` arrive together in WAIT, `Done` wins and `Start` is dropped.
- Reset values: `DIN=0`, `Run=0`, `PC=0`, `Busy=0`, `Halted=0`, state IDLE.
- Reset mid-operation forces the reset values immediately. Any in-flight instruction is abandoned.

## Timing
- Latency from `Start` to first instruction: `Start` sampled high at edge k, then `Run`=1 and `DIN`=`mem[0]` during cycle k+1.
- `Run` is exactly one cycle wide per instruction.
- For `mvi`, the immediate is on `DIN` in the cycle immediately after the `Run` cycle.
- `Done` sampled at edge j in WAIT gives the next `Run` in cycle j+1. Minimum spacing between issues is 2 cycles, or 3 for `mvi`.
- `DIN` is stable from the `Run` cycle until the next issue, apart from the IMM update.

## Configuration
- `IFS_SINGLE_STEP_EN` defined:
  - Adds input port `Step` (1 bit).
  - On `Done` in WAIT, the next word is not issued until `Step` is sampled high; this wait uses a STEP state.
  - `Step` during the `Done` cycle counts.
  - `Busy` stays high in STEP.
  - `Reset` in STEP returns to IDLE.
- Undefined: no `Step` port, no STEP state, free-running as above.

## Test plan
- Load `mem[0]=9'b000_001_010` (mv), `mem[1]=9'h1FF`. Pulse `Start`; `Done` 3 cycles after `Run`. Required: one `Run` with `DIN`=`0x00A`, then HALT with `Halted`=1 and `PC`=1.
- Load `mem[0]=9'b001_000_000` (mvi), `mem[1]=9'h05`, `mem[2]=9'h1FF`. Required: `Run` cycle `DIN`=`0x040`, next cycle `DIN`=`0x005` with `Run`=0, and `PC`=2 in WAIT.
- `DEPTH`=16, no HALT word in memory, `Done` returned promptly. Required: `PC` wraps 15→0 and issue continues.
- Assert `Reset` during WAIT. Required: all outputs go to reset values at once, and memory contents are intact on the next `Start`.
- While `Busy`: pulse `Load` to address 3 with `0x1FF`, and pulse `Start`. Required: `mem[3]` unchanged, no restart. Pulse `Done` during IMM: ignored.
- With `IFS_SINGLE_STEP_EN`: after `Done`, `Run` stays low until `Step` is pulsed, then `Run` in the next cycle.
